bw_mac_accumulator: RTL and testbench
=====================================

# bw_mac_accumulator

Signed multiply-accumulate stage directly downstream of the 4x4 Baugh-Wooley multiplier array. Accepts the array's 8-bit two's-complement products over a valid/ready handshake and sums a frame of up to `N_TERMS` products into an `ACC_W`-bit signed accumulator. Presents the frame total, term count and overflow flag on a held output handshake. This converts the purely combinational multiplier into a streaming dot-product datapath.

## Interface
- `N_TERMS`, default 4: maximum products per frame; range 1..31.
- `ACC_W`, default 12: accumulator width in bits, signed; minimum 8.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `prod` holds a valid product.
- `in_ready`  out  1  stage can accept a product this cycle.
- `prod`  in  8  signed product from the multiplier array; range -56..+64.
- `in_last`  in  1  qualifies `prod` as the final term of the frame, ending it early.
- `out_valid`  out  1  frame result available.
- `out_ready`  in  1  consumer takes the result.
- `out_sum`  out  `ACC_W`  signed frame sum.
- `out_count`  out  5  number of terms accumulated, 1..`N_TERMS`.
- `out_ovf`  out  1  sum left the signed `ACC_W` range at some point during the frame.

## Operation
- **States:**
  - IDLE: accumulator clear, no term accepted yet.
  - ACC: one or more terms accepted.
  - HOLD: result presented.
- **Accept:** a term is accepted when `in_valid && in_ready`. The update is `acc <= acc + sext(prod)`, computed at `ACC_W+1` bits, and `cnt <= cnt+1`.
- **Frame end:** the frame ends on the accept where `in_last=1` or `cnt+1 == N_TERMS`, whichever comes first. The state moves to HOLD.
- **Other transitions:**
  - IDLE → ACC on any non-final accept.
  - ACC stays in ACC on non-final accepts.
  - HOLD → IDLE on `out_valid && out_ready`. This clears `acc`, `cnt` and `ovf`.
- **Overflow:** `ovf` is set when the `ACC_W+1` result differs from its sign-extended low `ACC_W` bits. It is sticky until the frame is consumed.
- **Ready and hold:**
  - `in_ready = (state != HOLD)`.
  - There is no same-cycle bypass from HOLD to the next frame.
- **Reset:** `rst` at any time, including mid-frame or in HOLD, forces IDLE and discards partial sums. Reset values:
  - `out_valid=0`, `in_ready=1` after release.
  - `out_sum=0`, `out_count=0`, `out_ovf=0`.
- **`in_last` masking:** `in_last` is ignored unless it accompanies an accept.

## Timing
- **Input:** accepts one product per cycle in IDLE/ACC with no bubbles.
- **Result latency:** `out_valid` rises in the cycle after the final accept (latency 1). `out_sum`, `out_count` and `out_ovf` are registered and stable while `out_valid=1`.
- **Output hold:** `out_valid` and the data are held unchanged until `out_ready`. `in_ready=0` throughout HOLD.
- **After handoff:** `in_ready` returns to 1 in the cycle after the output handshake. The minimum frame period is therefore count+1 cycles.
- **`N_TERMS=1`:** every accept is final.

## Configuration
- **`BW_MAC_SAT_EN` defined:**
  - On overflow the accumulator clamps to `2^(ACC_W-1)-1` (positive) or `-2^(ACC_W-1)` (negative) and stays clamped for later terms that push further out of range.
  - A term that brings the sum back in range is added to the clamped value.
  - `out_ovf` is still set.
- **`BW_MAC_SAT_EN` undefined:** the accumulator wraps modulo `2^ACC_W`; `out_ovf` is still set.

## Structure
- **Shared package `bw_pkg`:**
  - `PROD_W=8`.
  - `CNT_W=5`.
  - State enum `bw_mac_state_t` {IDLE, ACC, HOLD}.
  - Saturation limit functions parameterised by width.
- **Sub-module `bw_sat_add`:** combinational `ACC_W`-bit signed add with overflow detect and optional clamp. It is the only sub-module, and its clamp path is compiled only under `BW_MAC_SAT_EN`.

## Test plan
- **Full frame:** 4 products 0x40, `in_valid` continuous → `out_sum=256`, `out_count=4`, `out_ovf=0`, `out_valid` one cycle after 4th accept.
- **Mixed signs:** products 0xC8, 0x40, 0x00, 0xFF → `out_sum=7`, `out_count=4`.
- **Early end:** products 10 then 20 with `in_last` on second → `out_sum=30`, `out_count=2`.
- **Backpressure:** hold `out_ready=0` for 5 cycles in HOLD → `out_valid` and data stable, `in_ready=0`. Consume, then `in_ready=1` the next cycle.
- **Overflow (`ACC_W=8`), four products 0x40:**
  - Macro off → `out_sum=0x00`, `out_ovf=1`.
  - Macro on → `out_sum=0x7F`, `out_ovf=1`.
- **Reset mid-frame:** assert `rst` after 2 accepts, then run a fresh 4×0x01 frame → `out_sum=4`, `out_count=4`.

Source files
------------

// File: rtl/bw_pkg.sv
// Shared types and constants for the Baugh-Wooley MAC stage.
// Saturation limit helpers serve the clamp path enabled by BW_MAC_SAT_EN.
package bw_pkg;

   localparam int PROD_W = 8;
   localparam int CNT_W  = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } bw_mac_state_t;

   // Largest positive value of a w-bit signed number, in the low w bits.
   function automatic logic [31:0] sat_max(input int w);
      return (32'd1 << (w - 1)) - 32'd1;
   endfunction

   // Most negative value of a w-bit signed number, in the low w bits.
   function automatic logic [31:0] sat_min(input int w);
      return 32'd1 << (w - 1);
   endfunction

endpackage

// File: rtl/bw_sat_add.sv
// Combinational W-bit signed adder with overflow detect.
// With BW_MAC_SAT_EN defined an overflowing result clamps to the signed limit.
module bw_sat_add
   import bw_pkg::*;
#(
   parameter int W = 12
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   output logic signed [W-1:0] sum,
   output logic                ovf
);

   logic signed [W:0] full_s;

   // One extra bit exposes overflow: the true sign sits in full_s[W].
   always_comb begin
      full_s = (W+1)'(a) + (W+1)'(b);
      ovf    = (full_s[W] != full_s[W-1]);
`ifdef BW_MAC_SAT_EN
      if (ovf) begin
         if (full_s[W]) begin
            sum = W'(sat_min(W));
         end else begin
            sum = W'(sat_max(W));
         end
      end else begin
         sum = full_s[W-1:0];
      end
`else
      sum = full_s[W-1:0];
`endif
   end

endmodule

// File: rtl/bw_mac_accumulator.sv
// Streaming signed MAC: sums a frame of up to N_TERMS multiplier products.
// Optional saturation (BW_MAC_SAT_EN) lives in bw_sat_add.
module bw_mac_accumulator
   import bw_pkg::*;
#(
   parameter int N_TERMS = 4,
   parameter int ACC_W   = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       prod,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [4:0]       out_count,
   output logic             out_ovf
);

   bw_mac_state_t            state_r;
   bw_mac_state_t            state_nxt_s;
   logic signed [ACC_W-1:0]  acc_r;
   logic [CNT_W-1:0]         cnt_r;
   logic                     ovf_r;
   logic                     accept_s;
   logic                     final_s;
   logic                     consume_s;
   logic signed [ACC_W-1:0]  prod_ext_s;
   logic signed [ACC_W-1:0]  sum_s;
   logic                     add_ovf_s;

   // Handshake qualifiers; the frame closes on in_last or on the N_TERMS-th term.
   always_comb begin
      accept_s   = in_valid && (state_r != HOLD);
      final_s    = accept_s && (in_last || (cnt_r == CNT_W'(N_TERMS - 1)));
      consume_s  = (state_r == HOLD) && out_ready;
      prod_ext_s = ACC_W'($signed(prod));
   end

   bw_sat_add #(
      .W (ACC_W)
   ) u_add (
      .a   (acc_r),
      .b   (prod_ext_s),
      .sum (sum_s),
      .ovf (add_ovf_s)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE, ACC: begin
            if (final_s) begin
               state_nxt_s = HOLD;
            end else if (accept_s) begin
               state_nxt_s = ACC;
            end else begin
               state_nxt_s = state_r;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = HOLD;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Handshake outputs decoded from the state register.
   always_comb begin
      in_ready  = 1'b1;
      out_valid = 1'b0;
      case (state_r)
         IDLE, ACC: begin
            in_ready  = 1'b1;
            out_valid = 1'b0;
         end
         HOLD: begin
            in_ready  = 1'b0;
            out_valid = 1'b1;
         end
         default: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
         end
      endcase
   end

   // Accumulator, term count and sticky overflow; frozen in HOLD, cleared on handoff.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r <= '0;
         cnt_r <= '0;
         ovf_r <= 1'b0;
      end else if (consume_s) begin
         acc_r <= '0;
         cnt_r <= '0;
         ovf_r <= 1'b0;
      end else if (accept_s) begin
         acc_r <= sum_s;
         cnt_r <= cnt_r + CNT_W'(1);
         ovf_r <= ovf_r | add_ovf_s;
      end else begin
         acc_r <= acc_r;
         cnt_r <= cnt_r;
         ovf_r <= ovf_r;
      end
   end

   always_comb begin
      out_sum   = acc_r;
      out_count = cnt_r;
      out_ovf   = ovf_r;
   end

endmodule

// File: tb/tb_bw_mac_accumulator.sv
// Directed self-checking bench for bw_mac_accumulator (default and ACC_W=8 builds).
// Overflow expectation follows BW_MAC_SAT_EN.
module tb_bw_mac_accumulator;

   logic        clk;
   logic        rst;
   logic        in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
   logic [7:0]  prod;
   logic [11:0] out_sum;
   logic [4:0]  out_count;

   logic        v2, rdy2, l2, ov2, r2, ovf2;
   logic [7:0]  p2;
   logic [7:0]  sum2;
   logic [4:0]  cnt2;

   int errors = 0;
   int checks = 0;

   bw_mac_accumulator #(.N_TERMS(4), .ACC_W(12)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .prod      (prod),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_count (out_count),
      .out_ovf   (out_ovf)
   );

   bw_mac_accumulator #(.N_TERMS(4), .ACC_W(8)) u_ovf (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (v2),
      .in_ready  (rdy2),
      .prod      (p2),
      .in_last   (l2),
      .out_valid (ov2),
      .out_ready (r2),
      .out_sum   (sum2),
      .out_count (cnt2),
      .out_ovf   (ovf2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [31:0] ovf_sum_exp;
`ifdef BW_MAC_SAT_EN
      ovf_sum_exp = 32'h7F;
`else
      ovf_sum_exp = 32'h00;
`endif
      rst = 1'b1; in_valid = 1'b0; prod = 8'h00; in_last = 1'b0; out_ready = 1'b0;
      v2 = 1'b0; p2 = 8'h00; l2 = 1'b0; r2 = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid", out_valid, 32'd0);
      chk("rst_sum",   out_sum,   32'd0);
      chk("rst_count", out_count, 32'd0);
      chk("rst_ovf",   out_ovf,   32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", in_ready, 32'd1);

      // Full frame of four 0x40 products
      in_valid = 1'b1; prod = 8'h40;
      repeat (3) @(negedge clk);
      chk("full_mid_valid", out_valid, 32'd0);
      chk("full_mid_ready", in_ready,  32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("full_valid", out_valid, 32'd1);
      chk("full_sum",   out_sum,   32'd256);
      chk("full_count", out_count, 32'd4);
      chk("full_ovf",   out_ovf,   32'd0);
      chk("full_ready", in_ready,  32'd0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("full_done_valid", out_valid, 32'd0);
      chk("full_done_ready", in_ready,  32'd1);
      chk("full_done_sum",   out_sum,   32'd0);

      // Mixed signs: -56 + 64 + 0 - 1 = 7
      in_valid = 1'b1;
      prod = 8'hC8; @(negedge clk);
      prod = 8'h40; @(negedge clk);
      prod = 8'h00; @(negedge clk);
      prod = 8'hFF; @(negedge clk);
      in_valid = 1'b0;
      chk("mix_valid", out_valid, 32'd1);
      chk("mix_sum",   out_sum,   32'd7);
      chk("mix_count", out_count, 32'd4);
      chk("mix_ovf",   out_ovf,   32'd0);
      out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;

      // in_last without in_valid must not close anything
      in_last = 1'b1; @(negedge clk); in_last = 1'b0;
      chk("mask_valid", out_valid, 32'd0);
      chk("mask_count", out_count, 32'd0);

      // Early end: 10 then 20 with in_last
      in_valid = 1'b1;
      prod = 8'd10; @(negedge clk);
      prod = 8'd20; in_last = 1'b1; @(negedge clk);
      prod = 8'h33; in_last = 1'b0;
      chk("early_valid", out_valid, 32'd1);
      chk("early_sum",   out_sum,   32'd30);
      chk("early_count", out_count, 32'd2);

      // Backpressure with in_valid still asserted
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", out_valid, 32'd1);
         chk("bp_sum",   out_sum,   32'd30);
         chk("bp_count", out_count, 32'd2);
         chk("bp_ready", in_ready,  32'd0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_done_valid", out_valid, 32'd0);
      chk("bp_done_ready", in_ready,  32'd1);
      chk("bp_done_count", out_count, 32'd0);

      // Overflow on the ACC_W=8 instance
      v2 = 1'b1; p2 = 8'h40;
      repeat (4) @(negedge clk);
      v2 = 1'b0;
      chk("ovf_valid", ov2,  32'd1);
      chk("ovf_sum",   sum2, ovf_sum_exp);
      chk("ovf_flag",  ovf2, 32'd1);
      chk("ovf_count", cnt2, 32'd4);
      r2 = 1'b1; @(negedge clk); r2 = 1'b0;
      chk("ovf_done_valid", ov2,  32'd0);
      chk("ovf_done_flag",  ovf2, 32'd0);

      // Reset mid-frame, then a fresh 4 x 0x01 frame
      in_valid = 1'b1; prod = 8'h05;
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
      chk("mid_count", out_count, 32'd2);
      rst = 1'b1;
      #1;
      chk("mid_rst_sum",   out_sum,   32'd0);
      chk("mid_rst_count", out_count, 32'd0);
      chk("mid_rst_valid", out_valid, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rel_ready", in_ready, 32'd1);
      in_valid = 1'b1; prod = 8'h01;
      repeat (4) @(negedge clk);
      in_valid = 1'b0;
      chk("fresh_valid", out_valid, 32'd1);
      chk("fresh_sum",   out_sum,   32'd4);
      chk("fresh_count", out_count, 32'd4);
      chk("fresh_ovf",   out_ovf,   32'd0);
      out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
